// File: rtl/seven_segment_reader_if.sv
// Display-bus bundle for seven_segment_reader: the snooped anode/segment lines
// plus the recovered digit state.
interface seven_segment_reader_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   an;
    logic [6:0]          segment;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   blank_mask;
    logic [DIGITS-1:0]   valid_mask;
    logic                frame_valid;
    logic                err;

    modport master (
        output an, segment,
        input  digits, blank_mask, valid_mask, frame_valid, err
    );

    modport slave (
        input  an, segment,
        output digits, blank_mask, valid_mask, frame_valid, err
    );
endinterface

// File: rtl/seven_segment_reader.sv
// Recovers digit values from a multiplexed active-low 7-segment bus.
// Define SEVEN_SEGMENT_READER_HEX_EN to also decode A-F.
module seven_segment_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic                  clk,
    input logic                  rst,
    seven_segment_reader_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t              state_q, state_d;
    logic [DIGITS-1:0]   s_an_q, s_an_d;
    logic [6:0]          s_seg_q, s_seg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic                frame_q, frame_d;
    logic                err_q, err_d;

    logic                changed;
    logic                capture;
    logic [DIGITS-1:0]   an_sel;
    logic                an_legal;
    logic                dec_ok;
    logic                dec_blank;
    logic [3:0]          dec_val;
    logic [DIGITS-1:0]   seen_n;

    always_comb begin
        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        dec_val   = 4'h0;
        case (s_seg_q)
            7'b1000000: dec_val = 4'h0;
            7'b1111001: dec_val = 4'h1;
            7'b0100100: dec_val = 4'h2;
            7'b0110000: dec_val = 4'h3;
            7'b0011001: dec_val = 4'h4;
            7'b0010010: dec_val = 4'h5;
            7'b0000010: dec_val = 4'h6;
            7'b1111000: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0010000: dec_val = 4'h9;
            7'b1111111: dec_blank = 1'b1;
`ifdef SEVEN_SEGMENT_READER_HEX_EN
            7'b0001000: dec_val = 4'hA;
            7'b0000011: dec_val = 4'hB;
            7'b1000110: dec_val = 4'hC;
            7'b0100001: dec_val = 4'hD;
            7'b0000110: dec_val = 4'hE;
            7'b0001110: dec_val = 4'hF;
`endif
            default:    dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        s_an_d   = bus.an;
        s_seg_d  = bus.segment;
        state_d  = state_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        blank_d  = blank_q;
        valid_d  = valid_q;
        seen_d   = seen_q;
        frame_d  = 1'b0;
        err_d    = 1'b0;

        // A new sample arriving on the would-be capture edge wins over capture.
        changed  = {bus.an, bus.segment} != {s_an_q, s_seg_q};
        capture  = (state_q == SETTLE) && !changed && (cnt_q == CW'(STABLE_CYCLES));
        an_sel   = ~s_an_q;
        an_legal = $onehot(an_sel);
        seen_n   = (|(seen_q & an_sel)) ? an_sel : (seen_q | an_sel);

        if (changed) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CW'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (changed) begin
            state_d = (&bus.an) ? IDLE : SETTLE;
        end else if (capture) begin
            state_d = HELD;
        end

        if (capture) begin
            if (an_legal && dec_ok) begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (an_sel[i]) begin
                        digits_d[4*i +: 4] = dec_val;
                        blank_d[i]         = dec_blank;
                        valid_d[i]         = 1'b1;
                    end
                end
                if (&seen_n) begin
                    frame_d = 1'b1;
                    seen_d  = '0;
                end else begin
                    seen_d  = seen_n;
                end
            end else begin
                err_d  = 1'b1;
                seen_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s_an_q   <= '1;
            s_seg_q  <= '1;
            cnt_q    <= '0;
            digits_q <= '0;
            blank_q  <= '0;
            valid_q  <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_an_q   <= s_an_d;
            s_seg_q  <= s_seg_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            blank_q  <= blank_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.blank_mask  = blank_q;
    assign bus.valid_mask  = valid_q;
    assign bus.frame_valid = frame_q;
    assign bus.err         = err_q;
endmodule

// File: doc/seven_segment_reader.md
# seven_segment_reader

Recovers digit values by monitoring the segment and digit-select lines of a time-multiplexed, active-low 7-segment display. It sits opposite the display decoder. It samples the anode/segment bus, waits for each digit's pattern to stay stable, and maps the pattern back to a 4-bit value. It also reports blanks, illegal patterns and completed scan frames, for loopback self-test and for display-bus snooping.

## Interface
- `DIGITS`, 4: number of multiplexed digits (≥1).
- `STABLE_CYCLES`, 4: consecutive identical samples required before capture (≥2).
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `an` input DIGITS: digit select, active-low, one-hot when driving; all-ones = idle.
- `segment` input 7: active-low pattern, bit0 = a … bit6 = g.
- `digits` output 4*DIGITS: decoded value of digit i in bits [4i+3:4i].
- `blank_mask` output DIGITS: bit i set when digit i's last capture was blank.
- `valid_mask` output DIGITS: sticky; bit i set once digit i has been captured since reset.
- `frame_valid` output 1: one-cycle pulse when every digit has been captured once in the current frame.
- `err` output 1: one-cycle pulse on an illegal stable pattern or an illegal stable anode value.

## Operation
- **Input stage:** `an`/`segment` registered into `s_an`/`s_seg` every cycle (reset value all-ones).
- **Stability counter `cnt`:**
  - Width `$clog2(STABLE_CYCLES+1)`.
  - Loads 1 when `{s_an,s_seg}` differs from the previous sample.
  - Otherwise increments, saturating at STABLE_CYCLES.
- **FSM states:** IDLE, SETTLE, HELD.
  - IDLE: `s_an` all-ones. Goes to SETTLE when `s_an` ≠ all-ones.
  - SETTLE: counting. Capture fires on the cycle `cnt` reaches STABLE_CYCLES, then → HELD.
  - HELD: no further capture. Any sample change → SETTLE (`cnt`=1), or → IDLE if `s_an` is all-ones.
- **Capture, legal `s_an` (exactly one zero at index i):**
  - Decode `s_seg` to value v:
    - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
    - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
    - 1111111 = blank: v = 0, `blank_mask[i]` = 1.
  - Legal pattern: write `digits[i]`, update `blank_mask[i]`, set `valid_mask[i]`.
  - Illegal pattern: pulse `err`; `digits`, `blank_mask` and `valid_mask` unchanged.
- **Capture, multi-hot `s_an`:** pulse `err`; no register update.
- **Frame tracking:** internal `seen` mask.
  - Legal capture of digit i with `seen[i]` = 0: `seen[i]` ← 1.
  - Legal capture of digit i with `seen[i]` = 1 (repeat before frame done): `seen` ← only bit i; no `frame_valid`.
  - `seen` becomes all-ones: pulse `frame_valid` in the same cycle as the update; `seen` ← 0.
  - Any `err`: `seen` ← 0.
- **Simultaneous events:** a change on the same edge that capture would fire is a change, not a capture (`cnt` reloads to 1).

## Timing
- **Reset values:** `digits` = 0, `blank_mask` = 0, `valid_mask` = 0, `frame_valid` = 0, `err` = 0; FSM in IDLE; `cnt` = 0; `seen` = 0.
- **Reset mid-operation:** discards any partial settle or frame. Capture requires a fresh STABLE_CYCLES run after `rst` deasserts.
- **Capture latency:** input first sampled at edge 1 → `digits`/`err`/`frame_valid` update at edge STABLE_CYCLES+1.
- **Short dwells:** a dwell shorter than STABLE_CYCLES+1 cycles is never captured and raises no error.
- **Pulse width:** `err` and `frame_valid` are exactly one cycle wide per capture event.
- **One capture per dwell:** a held pattern is captured once, regardless of length.

## Configuration
- **Macro:** `SEVEN_SEGMENT_READER_HEX_EN`.
- **Defined:** additionally decodes A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110 to 4'hA–4'hF.
- **Undefined:** these six patterns are illegal and produce `err`.

## Test plan
All scenarios use DIGITS = 4 and STABLE_CYCLES = 4.
- **Reset:** assert `rst` 2 cycles with arbitrary inputs → all outputs 0; `an` = 1111 held 10 cycles → no pulses.
- **Single capture:** `an` = 1110, `segment` = 0110000 held 8 cycles → `digits[3:0]` = 3 and `valid_mask` = 0001 at edge 5; one capture only.
- **Full frame:** scan digits 0–3 with 7, 1, 0, blank, 6 cycles each → `digits` = 16'h0017, `blank_mask` = 1000, single `frame_valid` pulse on digit 3's capture edge.
- **Errors:** `segment` = 1010101 stable on `an` = 1101 → `err` pulse, `digits` unchanged. Then `an` = 1100 stable → `err` pulse. Dwell of 3 cycles → nothing.
- **Hex macro:** `segment` = 0001110 stable → with macro `digits` nibble = F and no `err`; without macro `err` pulse only.
- **Repeat and reset:** digit 0 captured twice before digits 1–3 → no `frame_valid` until three further captures. `rst` asserted at `cnt` = 3 → no capture.
